// File: rtl/usb_fs_rx_pkg.sv
// Shared encodings for the full-speed USB receive front-end:
// line states, receiver FSM states, bit-stuffing limit and the line decode.
package usb_fs_rx_pkg;

    localparam logic [1:0] LS_SE0 = 2'd0;
    localparam logic [1:0] LS_J   = 2'd1;
    localparam logic [1:0] LS_K   = 2'd2;
    localparam logic [1:0] LS_SE1 = 2'd3;

    localparam int MAX_ONES               = 6;
    localparam int DEFAULT_SYNC_MIN_ZEROS = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_ABORT
    } rx_state_t;

    function automatic logic [1:0] decode_line(input logic p, input logic n);
        logic [1:0] ls;
        unique case ({p, n})
            2'b10:   ls = LS_J;
            2'b01:   ls = LS_K;
            2'b00:   ls = LS_SE0;
            default: ls = LS_SE1;
        endcase
        return ls;
    endfunction

endpackage

// File: rtl/usb_fs_rx_dpll.sv
// Line synchroniser, line-state decode and 4x-oversampling bit-clock recovery.
// Emits one registered sample per bit, taken one clock after the phase realigns.
module usb_fs_rx_dpll
    import usb_fs_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       usb_p_rx,
    input  logic       usb_n_rx,
    output logic [1:0] line_state,
    output logic       sample_valid,
    output logic [1:0] sample_state
);

    logic [SYNC_STAGES-1:0] p_sync;
    logic [SYNC_STAGES-1:0] n_sync;
    logic [1:0]             ls_next;
    logic [1:0]             phase;

    assign ls_next = decode_line(p_sync[SYNC_STAGES-1], n_sync[SYNC_STAGES-1]);

    // NOTE: all state here uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour, which is what makes the chain a chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_sync       <= '1;
            n_sync       <= '0;
            line_state   <= LS_J;
            phase        <= 2'd0;
            sample_valid <= 1'b0;
            sample_state <= LS_J;
        end else begin
            p_sync     <= {p_sync[SYNC_STAGES-2:0], usb_p_rx};
            n_sync     <= {n_sync[SYNC_STAGES-2:0], usb_n_rx};
            line_state <= ls_next;
            // Phase is zero in the first clock of every new level, so the
            // sample lands in its second clock and survives a 3-clock bit.
            phase        <= (ls_next != line_state) ? 2'd0 : phase + 2'd1;
            sample_valid <= (phase == 2'd1);
            if (phase == 2'd1) begin
                sample_state <= line_state;
            end
        end
    end

endmodule

// File: rtl/usb_fs_rx_frontend.sv
// Full-speed USB receive front-end: NRZI decode, bit unstuffing, packet
// framing FSM and bus-reset detection on top of the recovered bit samples.
module usb_fs_rx_frontend
    import usb_fs_rx_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int RESET_CYCLES   = 120,
    parameter int SYNC_MIN_ZEROS = DEFAULT_SYNC_MIN_ZEROS
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       usb_p_rx,
    input  logic       usb_n_rx,
    output logic [1:0] line_state,
    output logic       pkt_start,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       pkt_end,
    output logic       rx_err,
    output logic       bus_reset
);

    localparam int SE0_W = $clog2(RESET_CYCLES + 1);

    logic             sample_valid;
    logic [1:0]       sample_state;
    logic [1:0]       prev_sample;
    logic             decoded_bit;

    rx_state_t        state, state_n;
    logic [2:0]       zero_cnt, zero_cnt_n;
    logic [7:0]       shift, shift_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [2:0]       ones_cnt, ones_cnt_n;
    logic [7:0]       rx_data_n;
    logic             start_n, valid_n, end_n, err_n;
    logic [SE0_W-1:0] se0_cnt;

    usb_fs_rx_dpll #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_dpll (
        .clk          (clk),
        .reset_n      (reset_n),
        .usb_p_rx     (usb_p_rx),
        .usb_n_rx     (usb_n_rx),
        .line_state   (line_state),
        .sample_valid (sample_valid),
        .sample_state (sample_state)
    );

    // NRZI: an unchanged level is a 1, a transition is a 0.
    assign decoded_bit = (sample_state == prev_sample);

    // NOTE: every signal this block drives gets a default before any branch,
    // otherwise an uncovered path would hold its old value and infer a latch.
    always_comb begin
        state_n    = state;
        zero_cnt_n = zero_cnt;
        shift_n    = shift;
        bit_cnt_n  = bit_cnt;
        ones_cnt_n = ones_cnt;
        rx_data_n  = rx_data;
        start_n    = 1'b0;
        valid_n    = 1'b0;
        end_n      = 1'b0;
        err_n      = 1'b0;
        if (sample_valid) begin
            unique case (state)
                ST_IDLE: begin
                    if (sample_state == LS_K) begin
                        state_n    = ST_SYNC;
                        zero_cnt_n = 3'd1;
                    end
                end
                ST_SYNC: begin
                    if (sample_state == LS_SE0 || sample_state == LS_SE1) begin
                        state_n = ST_IDLE;
                    end else if (!decoded_bit) begin
                        if (zero_cnt != 3'd7) zero_cnt_n = zero_cnt + 3'd1;
                    end else if (int'(zero_cnt) >= SYNC_MIN_ZEROS) begin
                        state_n    = ST_DATA;
                        start_n    = 1'b1;
                        bit_cnt_n  = 3'd0;
                        ones_cnt_n = 3'd0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (sample_state == LS_SE0) begin
                        state_n = ST_EOP;
                        err_n   = (bit_cnt != 3'd0);
                    end else if (sample_state == LS_SE1) begin
                        state_n = ST_ABORT;
                        err_n   = 1'b1;
                    end else if (int'(ones_cnt) == MAX_ONES) begin
                        // This bit must be the stuffed 0; a 1 is a stuff error.
                        if (decoded_bit) begin
                            state_n = ST_ABORT;
                            err_n   = 1'b1;
                        end else begin
                            ones_cnt_n = 3'd0;
                        end
                    end else begin
                        shift_n    = {decoded_bit, shift[7:1]};
                        bit_cnt_n  = bit_cnt + 3'd1;
                        ones_cnt_n = decoded_bit ? ones_cnt + 3'd1 : 3'd0;
                        if (bit_cnt == 3'd7) begin
                            rx_data_n = shift_n;
                            valid_n   = 1'b1;
                        end
                    end
                end
                ST_EOP: begin
                    if (sample_state == LS_J) begin
                        state_n = ST_IDLE;
                        end_n   = 1'b1;
                    end else if (sample_state != LS_SE0) begin
                        state_n = ST_ABORT;
                        err_n   = 1'b1;
                    end
                end
                ST_ABORT: begin
                    if (sample_state == LS_J) begin
                        state_n = ST_IDLE;
                        end_n   = 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            prev_sample <= LS_J;
            zero_cnt    <= 3'd0;
            shift       <= 8'd0;
            bit_cnt     <= 3'd0;
            ones_cnt    <= 3'd0;
            rx_data     <= 8'd0;
            pkt_start   <= 1'b0;
            rx_valid    <= 1'b0;
            pkt_end     <= 1'b0;
            rx_err      <= 1'b0;
        end else begin
            state    <= state_n;
            zero_cnt <= zero_cnt_n;
            shift    <= shift_n;
            bit_cnt  <= bit_cnt_n;
            ones_cnt <= ones_cnt_n;
            rx_data  <= rx_data_n;
            pkt_start <= start_n;
            rx_valid  <= valid_n;
            pkt_end   <= end_n;
            rx_err    <= err_n;
            if (sample_valid) prev_sample <= sample_state;
        end
    end

    // se0_cnt holds the SE0 clocks already seen, so the output rises in the
    // RESET_CYCLES-th SE0 clock and drops in the first clock that is not SE0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            se0_cnt <= '0;
        end else if (line_state != LS_SE0) begin
            se0_cnt <= '0;
        end else if (se0_cnt != SE0_W'(RESET_CYCLES - 1)) begin
            se0_cnt <= se0_cnt + 1'b1;
        end
    end

    assign bus_reset = (line_state == LS_SE0) && (se0_cnt == SE0_W'(RESET_CYCLES - 1));

endmodule

// File: tb/tb_usb_fs_rx_frontend.sv
// Self-checking bench: packets are built from bytes by a bit-level encoder
// (stuffing + NRZI), and decoded bytes/strobes are compared to the source data.
module tb_usb_fs_rx_frontend;

    localparam int SYNC_STAGES  = 2;
    localparam int RESET_CYCLES = 120;

    localparam logic [1:0] L_SE0 = 2'd0;
    localparam logic [1:0] L_J   = 2'd1;
    localparam logic [1:0] L_K   = 2'd2;
    localparam logic [1:0] L_SE1 = 2'd3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       usb_p_rx;
    logic       usb_n_rx;
    logic [1:0] line_state;
    logic       pkt_start;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       pkt_end;
    logic       rx_err;
    logic       bus_reset;

    usb_fs_rx_frontend #(
        .SYNC_STAGES  (SYNC_STAGES),
        .RESET_CYCLES (RESET_CYCLES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .usb_p_rx   (usb_p_rx),
        .usb_n_rx   (usb_n_rx),
        .line_state (line_state),
        .pkt_start  (pkt_start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .pkt_end    (pkt_end),
        .rx_err     (rx_err),
        .bus_reset  (bus_reset)
    );

    always #10 clk = ~clk;

    typedef struct {
        string           name;
        logic [3:0][7:0] data;
        int              n;
        bit              bad_stuff;
        int              extra;
        bit              jitter;
        int              exp_valid;
        int              exp_err;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Event capture and per-cycle reference model (written only here).
    int         n_start = 0, n_valid = 0, n_end = 0, n_err = 0, n_br = 0;
    int         n_overlap = 0, ls_bad = 0, br_bad = 0;
    logic [7:0] got[$];
    logic [1:0] hist[$];
    logic [1:0] exp_ls = L_J;
    int         se0_run = 0;

    function automatic logic [1:0] pad_state(input logic p, input logic n);
        if (p && !n) return L_J;
        if (!p && n) return L_K;
        if (!p && !n) return L_SE0;
        return L_SE1;
    endfunction

    // line_state is the pad level seen SYNC_STAGES+1 edges earlier.
    always @(posedge clk) begin
        if (!reset_n) begin
            hist.delete();
            for (int i = 0; i < SYNC_STAGES + 1; i++) hist.push_back(L_J);
            exp_ls  <= L_J;
            se0_run <= 0;
        end else begin
            hist.push_back(pad_state(usb_p_rx, usb_n_rx));
            void'(hist.pop_front());
            exp_ls  <= hist[0];
            se0_run <= (hist[0] == L_SE0) ? se0_run + 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (pkt_start) n_start <= n_start + 1;
            if (rx_valid) begin
                n_valid <= n_valid + 1;
                got.push_back(rx_data);
            end
            if (pkt_end) n_end <= n_end + 1;
            if (rx_err) n_err <= n_err + 1;
            if (bus_reset) n_br <= n_br + 1;
            if (pkt_start && rx_valid) n_overlap <= n_overlap + 1;
            if (line_state != exp_ls) ls_bad <= ls_bad + 1;
            if (bus_reset != (se0_run >= RESET_CYCLES)) br_bad <= br_bad + 1;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic vec_t mk(input string name, input logic [31:0] data, input int n,
                                input bit bad, input int extra, input bit jit,
                                input int ev, input int ee);
        vec_t v;
        v.name = name; v.data = data; v.n = n; v.bad_stuff = bad; v.extra = extra;
        v.jitter = jit; v.exp_valid = ev; v.exp_err = ee;
        return v;
    endfunction

    task automatic drive_line(input logic [1:0] ls, input int dur);
        case (ls)
            L_J:     begin usb_p_rx = 1'b1; usb_n_rx = 1'b0; end
            L_K:     begin usb_p_rx = 1'b0; usb_n_rx = 1'b1; end
            L_SE0:   begin usb_p_rx = 1'b0; usb_n_rx = 1'b0; end
            default: begin usb_p_rx = 1'b1; usb_n_rx = 1'b1; end
        endcase
        repeat (dur) @(negedge clk);
    endtask

    // SYNC, stuffed data, EOP; the level list is cut after max_levels entries.
    task automatic send_packet(input vec_t v, input int max_levels);
        bit         bits[$];
        bit         data_bits[$];
        logic [1:0] lv[$];
        logic [1:0] cur;
        int         ones;
        for (int i = 0; i < 7; i++) bits.push_back(1'b0);
        bits.push_back(1'b1);
        if (v.bad_stuff) begin
            for (int i = 0; i < 7; i++) data_bits.push_back(1'b1);
        end else begin
            for (int k = 0; k < v.n; k++)
                for (int b = 0; b < 8; b++) data_bits.push_back(v.data[k][b]);
            for (int e = 0; e < v.extra; e++) data_bits.push_back(1'b0);
        end
        ones = 0;
        foreach (data_bits[i]) begin
            bits.push_back(data_bits[i]);
            if (!v.bad_stuff) begin
                ones = data_bits[i] ? ones + 1 : 0;
                if (ones == 6) begin
                    bits.push_back(1'b0);
                    ones = 0;
                end
            end
        end
        cur = L_J;
        foreach (bits[i]) begin
            if (!bits[i]) cur = (cur == L_J) ? L_K : L_J;
            lv.push_back(cur);
        end
        lv.push_back(L_SE0);
        lv.push_back(L_SE0);
        lv.push_back(L_J);
        foreach (lv[i]) begin
            if (i >= max_levels) return;
            drive_line(lv[i], v.jitter ? ((i % 2 == 1) ? 5 : 3) : 4);
        end
        drive_line(L_J, 24);
    endtask

    task automatic run_vec(input vec_t v);
        int s_start = n_start;
        int s_valid = n_valid;
        int s_end   = n_end;
        int s_err   = n_err;
        int base    = got.size();
        send_packet(v, 1 << 30);
        check({v.name, ".pkt_start"}, n_start - s_start, 1);
        check({v.name, ".rx_valid"},  n_valid - s_valid, v.exp_valid);
        check({v.name, ".rx_err"},    n_err - s_err,     v.exp_err);
        check({v.name, ".pkt_end"},   n_end - s_end,     1);
        for (int k = 0; k < v.exp_valid; k++) begin
            int g;
            g = (got.size() > base + k) ? int'(got[base + k]) : -1;
            check($sformatf("%s.byte%0d", v.name, k), g, int'(v.data[k]));
        end
    endtask

    vec_t vecs[9];

    initial begin
        int s_start, s_valid, s_end, s_err, s_br;
        vecs[0] = mk("a5",                32'h000000A5, 1, 1'b0, 0, 1'b0, 1, 0);
        vecs[1] = mk("ff_ff",             32'h0000FFFF, 2, 1'b0, 0, 1'b0, 2, 0);
        vecs[2] = mk("stuff_err",         32'h00000000, 0, 1'b1, 0, 1'b0, 0, 1);
        vecs[3] = mk("jitter_3c",         32'h0000003C, 1, 1'b0, 0, 1'b1, 1, 0);
        vecs[4] = mk("eop_misaligned",    32'h00000012, 1, 1'b0, 3, 1'b0, 1, 1);
        vecs[5] = mk("stuff_at_byte_end", 32'h000001FC, 2, 1'b0, 0, 1'b0, 2, 0);
        vecs[6] = mk("stuff_before_eop",  32'h000000FC, 1, 1'b0, 0, 1'b0, 1, 0);
        vecs[7] = mk("four_bytes",        32'h7E800100, 4, 1'b0, 0, 1'b0, 4, 0);
        vecs[8] = mk("jitter_multi",      32'h0055AAFF, 3, 1'b0, 0, 1'b1, 3, 0);

        reset_n  = 1'b0;
        usb_p_rx = 1'b1;
        usb_n_rx = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.line_state", int'(line_state), 1);
        check("reset.rx_data",    int'(rx_data),    0);
        check("reset.strobes",    int'({pkt_start, rx_valid, pkt_end, rx_err, bus_reset}), 0);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        check("idle.line_state", int'(line_state), 1);
        check("idle.no_start",   n_start, 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // SE0 held long enough to be a bus reset, then released to J.
        s_start = n_start; s_br = n_br;
        drive_line(L_SE0, 130);
        drive_line(L_J, 12);
        check("bus_reset.high_cycles", n_br - s_br, 130 - RESET_CYCLES + 1);
        check("bus_reset.cleared",     int'(bus_reset), 0);
        check("bus_reset.no_start",    n_start - s_start, 0);

        for (int i = 0; i < 30; i++) begin
            int   n;
            vec_t v;
            n = $urandom_range(1, 4);
            v = mk($sformatf("rand%0d", i), $urandom, n, 1'b0, 0,
                   1'($urandom_range(0, 1)), n, 0);
            run_vec(v);
            drive_line(L_J, $urandom_range(0, 20));
        end

        // Reset pulled in the middle of the first data byte.
        send_packet(vecs[0], 12);
        @(negedge clk);
        #2;
        reset_n  = 1'b0;
        usb_p_rx = 1'b1;
        usb_n_rx = 1'b0;
        #1;
        check("mid_reset.line_state", int'(line_state), 1);
        check("mid_reset.rx_data",    int'(rx_data),    0);
        check("mid_reset.strobes",    int'({pkt_start, rx_valid, pkt_end, rx_err, bus_reset}), 0);
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b1;
        s_start = n_start; s_valid = n_valid; s_end = n_end; s_err = n_err;
        repeat (40) @(negedge clk);
        check("after_reset.no_valid", n_valid - s_valid, 0);
        check("after_reset.no_end",   n_end - s_end,     0);
        check("after_reset.no_start", n_start - s_start, 0);
        check("after_reset.no_err",   n_err - s_err,     0);
        run_vec(mk("after_reset_pkt", 32'h000000C3, 1, 1'b0, 0, 1'b0, 1, 0));

        check("model.line_state",      ls_bad,    0);
        check("model.bus_reset",       br_bad,    0);
        check("start_valid_overlap",   n_overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
